// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges a CPU load/store request port to a word-wide single-port memory.
//   Word stores write directly. Sub-word stores do a read-modify-write on the
//   containing word. Loads extract and extend the addressed lane. Misaligned
//   and illegal-size requests complete with resp_err and touch no memory.
//
// Ports
//   clk, rst_n                : clock, synchronous active-low reset
//   req_valid / req_ready     : request handshake (accepted when both high)
//   req_write                 : 1 = store, 0 = load
//   req_size                  : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned              : zero-extend loads when 1, sign-extend when 0
//   req_addr                  : byte address
//   req_wdata                 : store data, right-aligned
//   resp_valid                : one-cycle completion pulse
//   resp_rdata                : extended load data (0 for stores/errors)
//   resp_err                  : misaligned or illegal-size request
//   Address                   : word-aligned memory address
//   WriteData                 : full word to memory
//   MemWrite / MemRead        : registered memory strobes
//   ReadData                  : memory read word
module load_store_unit #(
    parameter int unsigned READ_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData
);

    localparam logic [1:0] LAT = 2'(READ_LAT);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      r_state, w_state_nx;

    // Captured request fields
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;
    logic [15:0] r_wdata;
    logic [1:0]  r_cnt, w_cnt_nx;

    // Registered outputs and their next values
    logic [31:0] r_address, w_address_nx;
    logic [31:0] r_write_data, w_write_data_nx;
    logic        r_mem_write, w_mem_write_nx;
    logic        r_mem_read, w_mem_read_nx;
    logic        r_resp_valid, w_resp_valid_nx;
    logic [31:0] r_resp_rdata, w_resp_rdata_nx;
    logic        r_resp_err, w_resp_err_nx;

    logic        w_accept;
    logic        w_req_bad;

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wd[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wd} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | data;
    endfunction

    assign req_ready  = (r_state == IDLE) && rst_n;
    assign w_accept   = req_valid && req_ready;
    assign w_req_bad  = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign Address    = r_address;
    assign WriteData  = r_write_data;
    assign MemWrite   = r_mem_write;
    assign MemRead    = r_mem_read;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_address_nx    = r_address;
        w_write_data_nx = '0;
        w_mem_write_nx  = 1'b0;
        w_mem_read_nx   = 1'b0;
        w_resp_valid_nx = 1'b0;
        w_resp_rdata_nx = '0;
        w_resp_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_address_nx = {req_addr[31:2], 2'b00};
                    w_cnt_nx     = '0;
                    if (w_req_bad) begin
                        w_state_nx      = RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b1;
                    end else if (req_write && req_size == 2'b10) begin
                        w_state_nx      = WR;
                        w_mem_write_nx  = 1'b1;
                        w_write_data_nx = req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read
                        w_state_nx    = RD;
                        w_mem_read_nx = 1'b1;
                    end
                end
            end
            RD: begin
                if (r_cnt == LAT) begin
                    // ReadData is consumed directly at this edge, so no
                    // separate read-word register is needed
                    if (r_write) begin
                        w_state_nx      = WR;
                        w_mem_write_nx  = 1'b1;
                        w_write_data_nx = merge(ReadData, r_size, r_lane, r_wdata);
                    end else begin
                        w_state_nx      = RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_rdata_nx = extract(ReadData, r_size, r_lane, r_unsigned);
                    end
                end else begin
                    w_cnt_nx      = r_cnt + 2'd1;
                    w_mem_read_nx = 1'b1;
                end
            end
            WR: begin
                w_state_nx      = RESP;
                w_resp_valid_nx = 1'b1;
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_size       <= '0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_address    <= w_address_nx;
            r_write_data <= w_write_data_nx;
            r_mem_write  <= w_mem_write_nx;
            r_mem_read   <= w_mem_read_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rdata <= w_resp_rdata_nx;
            r_resp_err   <= w_resp_err_nx;
            if (w_accept) begin
                r_lane     <= req_addr[1:0];
                r_size     <= req_size;
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata[15:0];
            end
        end
    end

endmodule
